// File: rtl/binary_div_18_9_uni.sv
// binary_div_18_9_uni
//   Unsigned sequential radix-2 restoring divider. Divides an 18-bit dividend
//   by a 9-bit divisor and produces an 18-bit quotient and a 9-bit remainder.
//   It retires one quotient bit per enabled clock.
//
//   Handshake: the divider accepts start only while idle with en=1.
//   busy is high whenever the FSM is not IDLE. done is high for exactly one
//   enabled cycle, while the result is presented. Q, R and div_by_zero then
//   hold until the next result is written. en=0 freezes every register, so a
//   done strobe that is already high stays high during the stall.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   en           in   clock enable / global stall
//   start        in   request, sampled only in IDLE with en=1
//   A            in   dividend, captured on an accepted start
//   B            in   divisor, captured on an accepted start
//   Q            out  quotient (all ones on divide-by-zero)
//   R            out  remainder (zero on divide-by-zero)
//   busy         out  FSM not in IDLE
//   done         out  one-cycle result strobe
//   div_by_zero  out  qualifies the Q/R currently held
module binary_div_18_9_uni #(
    parameter int DW = 18,
    parameter int VW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          start,
    input  logic [DW-1:0] A,
    input  logic [VW-1:0] B,
    output logic [DW-1:0] Q,
    output logic [VW-1:0] R,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    // dvd starts out holding the dividend. Each quotient bit enters at the LSB
    // as a dividend bit leaves at the MSB. After DW steps, dvd holds the
    // quotient.
    logic [DW-1:0] dvd;
    logic [VW-1:0] rem;
    logic [VW-1:0] div_reg;
    logic [CW-1:0] cnt;

    // The shifted partial remainder needs one extra bit so that it cannot
    // overflow before the compare. After a successful subtract the result
    // is below the divisor, so VW bits are enough to store it.
    logic [VW:0]   rem_shift;
    logic [VW:0]   diff;
    logic          ge;
    logic [VW-1:0] rem_next;
    logic          last_iter;
    logic          diff_msb_unused;

    assign rem_shift       = {rem, dvd[DW-1]};
    assign diff            = rem_shift - {1'b0, div_reg};
    assign ge              = (rem_shift >= {1'b0, div_reg});
    assign rem_next        = ge ? diff[VW-1:0] : rem_shift[VW-1:0];
    assign last_iter       = (cnt == CW'(DW - 1));
    assign diff_msb_unused = diff[VW];

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    // A zero divisor skips the iterations and goes straight to the result.
                    state_next = (B != '0) ? CALC : DONE;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd         <= '0;
            rem         <= '0;
            div_reg     <= '0;
            cnt         <= '0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_reg <= B;
                        if (B != '0) begin
                            dvd <= A;
                            rem <= '0;
                            cnt <= '0;
                        end else begin
                            Q           <= '1;
                            R           <= '0;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    dvd <= {dvd[DW-2:0], ge};
                    rem <= rem_next;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        Q           <= {dvd[DW-2:0], ge};
                        R           <= rem_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
